// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit arbiter.
//   state_t        - arbiter FSM state encoding
//   DEF_N_REQ      - default number of requesters
//   DEF_GAP_CYCLES - default idle cycles forced between frames
//   clog2_min1()   - ceil(log2(v)), never below 1, so that degenerate
//                    parameter values still give a legal vector width
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_GAP       = 2'd3
   } state_t;

   localparam int DEF_N_REQ      = 4;
   localparam int DEF_GAP_CYCLES = 16;

   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req        in  N_REQ  request vector
//   last_grant in  IW     index granted most recently
//   valid      out 1      at least one request is pending
//   index      out IW     first requester at or after last_grant+1 (mod N_REQ)
module rr_picker
   import uart_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   localparam int IW   = clog2_min1(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last_grant,
   output logic             valid,
   output logic [IW-1:0]    index
);

   logic [IW-1:0] cand;

   // Walk the candidates from the furthest offset down to the nearest one,
   // so the last hit written is the one closest after last_grant.
   always_comb begin
      valid = 1'b0;
      index = '0;
      cand  = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = IW'((int'(last_grant) + k) % N_REQ);
         if (req[cand]) begin
            valid = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ requesters.
//   sys_clk   in  1        clock, rising edge
//   reset     in  1        asynchronous, active-high
//   req       in  N_REQ    level request per requester, held until ack
//   req_data  in  8*N_REQ  byte of requester i at [8i+7:8i]
//   ack       out N_REQ    one-cycle pulse: byte of requester i captured
//   tx_start  out 1        one-cycle pulse: tx_data is valid
//   tx_data   out 8        captured byte, stable until the next capture
//   tx_done   in  1        end-of-frame pulse from the transmitter
//   grant_id  out IW       requester owning the transmitter
//   active    out 1        high in every state except IDLE
// All outputs are registered.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ      = DEF_N_REQ,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES,
   localparam int IW        = clog2_min1(N_REQ),
   localparam int GW        = clog2_min1(GAP_CYCLES + 1)
) (
   input  logic               sys_clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   ack,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   input  logic               tx_done,
   output logic [IW-1:0]      grant_id,
   output logic               active
);

   state_t           state, state_nxt;
   logic [IW-1:0]    last_grant;
   logic [GW-1:0]    gap_cnt;
   logic             pick_vld;
   logic [IW-1:0]    pick_idx;
   logic [N_REQ-1:0] ack_nxt;
   logic             tx_start_nxt;
   logic             active_nxt;
   logic             select;

   rr_picker #(.N_REQ(N_REQ)) u_pick (
      .req        (req),
      .last_grant (last_grant),
      .valid      (pick_vld),
      .index      (pick_idx)
   );

   assign select = (state == ST_IDLE) && pick_vld;

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:      if (pick_vld) state_nxt = ST_LAUNCH;
         ST_LAUNCH:    state_nxt = ST_WAIT_DONE;
         ST_WAIT_DONE: if (tx_done) state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
         ST_GAP:       if (gap_cnt == '0) state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   // Pulses are computed one cycle early so they are registered and
   // coincide with the LAUNCH state.
   always_comb begin
      ack_nxt      = '0;
      tx_start_nxt = 1'b0;
      active_nxt   = (state_nxt != ST_IDLE);
      if (select) begin
         ack_nxt[pick_idx] = 1'b1;
         tx_start_nxt      = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         ack        <= '0;
         tx_start   <= 1'b0;
         tx_data    <= 8'h00;
         grant_id   <= '0;
         active     <= 1'b0;
         last_grant <= IW'(N_REQ - 1);
         gap_cnt    <= '0;
      end else begin
         ack      <= ack_nxt;
         tx_start <= tx_start_nxt;
         active   <= active_nxt;
         if (select) begin
            tx_data  <= req_data[8*pick_idx +: 8];
            grant_id <= pick_idx;
         end
         if (state == ST_LAUNCH) last_grant <= grant_id;
         // Loaded with GAP_CYCLES-1 so the exit on zero yields exactly
         // GAP_CYCLES cycles in GAP; it never decrements past zero.
         if (state == ST_WAIT_DONE && tx_done)
            gap_cnt <= GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
         else if (state == ST_GAP && gap_cnt != '0)
            gap_cnt <= gap_cnt - GW'(1);
      end
   end

endmodule
